// File: rtl/i2c_scl_gen_pkg.sv
// Shared types and constants for the I2C SCL generator and its helpers.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        WAIT_HIGH,
        HIGH
    } state_t;

    localparam int HP_MIN      = 2;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control/status bundle between the master bit FSM and the SCL generator.
// Optional macro I2C_STRETCH_TIMEOUT_EN adds the stretch_limit field.
interface i2c_scl_gen_if #(
    parameter int DIV_W     = 16
`ifdef I2C_STRETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 20
`endif
);

    logic             en;
    logic [DIV_W-1:0] half_period;
    logic             scl_in;
    logic             scl_out;
    logic             strob_down;
    logic             strob_up;
    logic             strob_mid_low;
    logic             strob_mid_high;
    logic             stretching;
    logic             busy;
    logic             timeout;
`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] stretch_limit;
`endif

    modport master (
`ifdef I2C_STRETCH_TIMEOUT_EN
        output stretch_limit,
`endif
        output en,
        output half_period,
        input  scl_out,
        input  strob_down,
        input  strob_up,
        input  strob_mid_low,
        input  strob_mid_high,
        input  stretching,
        input  busy,
        input  timeout
    );

    modport slave (
`ifdef I2C_STRETCH_TIMEOUT_EN
        input  stretch_limit,
`endif
        input  en,
        input  half_period,
        input  scl_in,
        output scl_out,
        output strob_down,
        output strob_up,
        output strob_mid_low,
        output strob_mid_high,
        output stretching,
        output busy,
        output timeout
    );

endinterface

// File: rtl/i2c_sync2.sv
// Multi-flop synchroniser for asynchronous I2C pad inputs (SCL and SDA).
module i2c_sync2
    import i2c_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// Run-time programmable I2C SCL generator with clock stretching and strobes.
// Optional macro I2C_STRETCH_TIMEOUT_EN enables the stretch timeout.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W     = 16
`ifdef I2C_STRETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 20
`endif
) (
    input logic          clk,
    input logic          rst,
    i2c_scl_gen_if.slave bus
);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_hp;
    logic             r_scl;
    logic             r_down;
    logic             r_up;
    logic             r_ml;
    logic             r_mh;
    logic             r_str;
    logic             r_busy;
    logic             r_to;
`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tcnt;
`endif

    logic             w_sync;
    logic [DIV_W-1:0] w_hp_eff;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] w_mid;
    logic             w_last;

    i2c_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_scl (
        .clk (clk),
        .rst (rst),
        .i_d (bus.scl_in),
        .o_q (w_sync)
    );

    // Very short phases would collide the edge and mid strobes.
    assign w_hp_eff = (bus.half_period < DIV_W'(HP_MIN)) ?
                      DIV_W'(HP_MIN) : bus.half_period;
    assign w_cnt_nx = r_cnt + DIV_W'(1);
    assign w_mid    = r_hp >> 1;
    assign w_last   = (r_cnt == r_hp - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hp    <= '0;
            r_scl   <= 1'b1;
            r_down  <= 1'b0;
            r_up    <= 1'b0;
            r_ml    <= 1'b0;
            r_mh    <= 1'b0;
            r_str   <= 1'b0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
        end else begin
            r_down <= 1'b0;
            r_up   <= 1'b0;
            r_ml   <= 1'b0;
            r_mh   <= 1'b0;
            r_to   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_scl  <= 1'b1;
                    r_str  <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.en) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_hp    <= w_hp_eff;
                        r_scl   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_down  <= 1'b1;
                    end
                end
                LOW: begin
                    if (w_last) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= '0;
                        r_scl   <= 1'b1;
                        r_str   <= 1'b1;
`ifdef I2C_STRETCH_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end else begin
                        r_cnt <= w_cnt_nx;
                        r_ml  <= (w_cnt_nx == w_mid);
                    end
                end
                WAIT_HIGH: begin
                    if (w_sync) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_hp    <= w_hp_eff;
                        r_str   <= 1'b0;
                        r_up    <= 1'b1;
`ifdef I2C_STRETCH_TIMEOUT_EN
                    end else if ((bus.stretch_limit != '0) &&
                                 (r_tcnt == bus.stretch_limit -
                                            TIMEOUT_W'(1))) begin
                        r_state <= IDLE;
                        r_scl   <= 1'b1;
                        r_str   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_to    <= 1'b1;
                    end else begin
                        r_tcnt  <= r_tcnt + TIMEOUT_W'(1);
`endif
                    end
                end
                HIGH: begin
                    // Stop requests only take effect here, so SCL parks high.
                    if (w_last) begin
                        r_cnt <= '0;
                        if (bus.en) begin
                            r_state <= LOW;
                            r_hp    <= w_hp_eff;
                            r_scl   <= 1'b0;
                            r_down  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_nx;
                        r_mh  <= (w_cnt_nx == w_mid);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.scl_out        = r_scl;
    assign bus.strob_down     = r_down;
    assign bus.strob_up       = r_up;
    assign bus.strob_mid_low  = r_ml;
    assign bus.strob_mid_high = r_mh;
    assign bus.stretching     = r_str;
    assign bus.busy           = r_busy;
    assign bus.timeout        = r_to;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: timeline model plus directed edge-distance checks.
module tb_i2c_scl_gen;

    localparam int DIV_W     = 16;
    localparam int TIMEOUT_W = 20;

    localparam int PI = 0;
    localparam int PL = 1;
    localparam int PW = 2;
    localparam int PH = 3;

    logic clk = 1'b0;
    logic rst;
    logic hold;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    always #5 clk = ~clk;

`ifdef I2C_STRETCH_TIMEOUT_EN
    i2c_scl_gen_if #(.DIV_W(DIV_W), .TIMEOUT_W(TIMEOUT_W)) bus ();
    i2c_scl_gen #(.DIV_W(DIV_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    i2c_scl_gen_if #(.DIV_W(DIV_W)) bus ();
    i2c_scl_gen #(.DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    // Slave pulls the open-drain line low while hold is set.
    assign bus.scl_in = bus.scl_out & ~hold;

    // Model: phases described by start cycle and length.
    int   cyc = 0;
    int   ph  = PI;
    int   t0  = 0;
    int   mhp = 2;
    bit   m_ok = 1'b0;
    bit   padh [8];
    logic m_scl = 1'b1;
    logic m_down = 1'b0;
    logic m_up = 1'b0;
    logic m_ml = 1'b0;
    logic m_mh = 1'b0;
    logic m_str = 1'b0;
    logic m_busy = 1'b0;
    logic m_to = 1'b0;

    function automatic int clampf(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    always @(posedge clk) begin
        padh[cyc % 8] = m_scl & ~hold;
        cyc = cyc + 1;
        m_to = 1'b0;
        if (rst) begin
            ph = PI;
            m_ok = 1'b1;
            for (int i = 0; i < 8; i++) padh[i] = 1'b1;
        end else begin
            case (ph)
                PI: if (bus.en) begin
                    ph = PL; t0 = cyc;
                    mhp = clampf(int'(bus.half_period));
                end
                PL: if (cyc - t0 == mhp) begin
                    ph = PW; t0 = cyc;
                end
                PW: begin
                    // Line level is seen two flops (plus one decision) later.
                    if (padh[(cyc + 5) % 8]) begin
                        ph = PH; t0 = cyc;
                        mhp = clampf(int'(bus.half_period));
                    end
`ifdef I2C_STRETCH_TIMEOUT_EN
                    else if (int'(bus.stretch_limit) != 0 &&
                             cyc - t0 == int'(bus.stretch_limit)) begin
                        ph = PI; m_to = 1'b1;
                    end
`endif
                end
                default: if (cyc - t0 == mhp) begin
                    if (bus.en) begin
                        ph = PL; t0 = cyc;
                        mhp = clampf(int'(bus.half_period));
                    end else begin
                        ph = PI;
                    end
                end
            endcase
        end
        m_scl  = (ph != PL);
        m_down = (ph == PL) && (cyc == t0);
        m_ml   = (ph == PL) && (cyc - t0 == mhp / 2);
        m_up   = (ph == PH) && (cyc == t0);
        m_mh   = (ph == PH) && (cyc - t0 == mhp / 2);
        m_str  = (ph == PW);
        m_busy = (ph != PI);
    end

    logic [7:0] act_v;
    logic [7:0] exp_v;
    assign act_v = {bus.scl_out, bus.strob_down, bus.strob_up,
                    bus.strob_mid_low, bus.strob_mid_high,
                    bus.stretching, bus.busy, bus.timeout};
    assign exp_v = {m_scl, m_down, m_up, m_ml, m_mh, m_str, m_busy, m_to};

    always @(negedge clk) begin
        if (m_ok) begin
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL model cycle %0d: got %b, expected %b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.strob_down;
            1:       return bus.strob_up;
            2:       return bus.strob_mid_low;
            3:       return bus.strob_mid_high;
            4:       return bus.stretching;
            5:       return !bus.busy;
            default: return bus.timeout;
        endcase
    endfunction

    task automatic wait_for(input int which, input string nm, output int t);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sig(which) && k < 400);
        if (!sig(which)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_%s: got timeout, expected event", nm);
        end
        t = cyc;
    endtask

    int td, tu, tm, tw, ti, trst;

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        bus.en = 1'b0;
        bus.half_period = 16'd10;
`ifdef I2C_STRETCH_TIMEOUT_EN
        bus.stretch_limit = '0;
`endif
        repeat (2) @(negedge clk);
        check("reset_scl", int'(bus.scl_out), 1);
        check("reset_busy", int'(bus.busy), 0);
        rst = 1'b0;

        bus.en = 1'b1;
        wait_for(0, "down", td);
        wait_for(2, "mid_low", tm);
        check("down_to_midlow", tm - td, 5);
        wait_for(1, "up", tu);
        check("down_to_up", tu - td, 13);
        wait_for(3, "mid_high", tm);
        check("up_to_midhigh", tm - tu, 5);
        wait_for(0, "down", tm);
        check("period", tm - td, 23);

        hold = 1'b1;
        wait_for(4, "stretch", tw);
        repeat (20) @(negedge clk);
        hold = 1'b0;
        wait_for(1, "up", tu);
        check("stretch_len", tu - tw, 23);
        wait_for(0, "down", td);
        check("high_after_stretch", td - tu, 10);

        bus.half_period = 16'd8;
        wait_for(1, "up", tu);
        wait_for(0, "down", td);
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        wait_for(1, "up", tu);
        check("stop_low_wait", tu - td, 11);
        wait_for(5, "idle", ti);
        check("stop_high_len", ti - tu, 8);
        check("stop_scl", int'(bus.scl_out), 1);
        repeat (5) @(negedge clk);
        check("parked_busy", int'(bus.busy), 0);

        bus.half_period = 16'd0;
        bus.en = 1'b1;
        wait_for(0, "down", td);
        wait_for(1, "up", tu);
        check("clamp_low", tu - td, 5);
        bus.half_period = 16'd6;
        wait_for(0, "down", td);
        check("reprog_cur", td - tu, 2);
        wait_for(1, "up", tu);
        check("reprog_next", tu - td, 9);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        trst = cyc;
        check("rst_scl", int'(bus.scl_out), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_strobes", int'({bus.strob_down, bus.strob_up,
              bus.strob_mid_low, bus.strob_mid_high, bus.stretching}), 0);
        rst = 1'b0;
        wait_for(0, "down", td);
        check("rst_restart", td - trst, 1);

`ifdef I2C_STRETCH_TIMEOUT_EN
        bus.stretch_limit = 20'd50;
        wait_for(0, "down", td);
        hold = 1'b1;
        wait_for(4, "stretch", tw);
        wait_for(6, "timeout", ti);
        check("timeout_delay", ti - tw, 50);
        check("timeout_scl", int'(bus.scl_out), 1);
        check("timeout_busy", int'(bus.busy), 0);
        hold = 1'b0;
        bus.stretch_limit = '0;
`endif

        bus.en = 1'b0;
        repeat (60) @(negedge clk);
        check("final_idle", int'(bus.busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised successor to the fixed I2C SCL divider.
- Generates SCL from the system clock using a half-period that software can change at run time.
- Supports clock stretching: slaves may hold SCL low, sensed via a 2-flop-synchronised scl_in.
- Emits one-cycle strobes at each SCL edge and at the middle of each phase (SDA change point, SDA sample point).
- Sits between the I2C master byte/bit FSM and the open-drain pad.

Parameters:
DIV_W, 16, width of half_period and of the phase counter
TIMEOUT_W, 20, width of the stretch-timeout counter (used only with the optional feature)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
en  in  1  run request; SCL toggles while high, parks high when low
half_period  in  DIV_W  clk cycles per SCL low phase and per high phase; sampled at every phase start
scl_in  in  1  raw SCL pad level (asynchronous)
scl_out  out  1  1 = release SCL (pad pulls high), 0 = drive low
strob_down  out  1  pulse in the first cycle of each low phase
strob_up  out  1  pulse in the first cycle of each high phase
strob_mid_low  out  1  pulse at the middle of the low phase (SDA change point)
strob_mid_high  out  1  pulse at the middle of the high phase (SDA sample point)
stretching  out  1  high while SCL is released but not yet seen high
busy  out  1  high in any state other than IDLE
timeout  out  1  one-cycle pulse on stretch timeout (tied 0 without the optional feature)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, counters 0, synchroniser flops 1.
  - Outputs: scl_out=1; all strobes, stretching, busy and timeout = 0.
  - Applies from any state, including mid-phase; no strobe is emitted for the aborted phase.
- hp_eff = max(half_period, 2). It is latched into hp_q on entry to LOW and to HIGH; changes mid-phase take effect next phase.
- Phase counter runs 0..hp_q-1. Mid strobe fires when count == hp_q>>1.
- States:
  - IDLE: scl_out=1. If en=1, go to LOW next cycle.
  - LOW: scl_out=0; strob_down in the cycle count==0. After hp_q cycles, go to WAIT_HIGH.
  - WAIT_HIGH: scl_out=1, stretching=1. Go to HIGH in the cycle after sync_scl==1 is observed.
  - HIGH: scl_out=1; strob_up in the cycle count==0. After hp_q cycles: if en=1, go to LOW, else go to IDLE.
- en deassertion is honoured only at the end of a HIGH phase, so SCL always completes a full period and parks high.
- Reasserting en during the same HIGH phase continues without a gap.
- Latency with no stretch (scl_in = scl_out, zero delay): WAIT_HIGH lasts exactly 3 cycles.
  - Period = 2*hp_q + 3 cycles: low = hp_q cycles, high = hp_q + 3 cycles.
- A stretch of N extra cycles on scl_in lengthens WAIT_HIGH by N cycles. The HIGH phase is never shortened.
- Strobes are registered, mutually exclusive, and each exactly 1 cycle wide.
- scl_in going low during HIGH (another master, arbitration) is ignored by this block; arbitration belongs to the master FSM.

Optional Feature:
- Macro: I2C_STRETCH_TIMEOUT_EN.
- When defined: an extra input stretch_limit [TIMEOUT_W-1:0] is added.
  - A counter runs while in WAIT_HIGH.
  - When it reaches stretch_limit (stretch_limit != 0): timeout pulses for 1 cycle and the state goes to IDLE with scl_out=1.
  - stretch_limit == 0 disables the check.
- When not defined: no extra port; timeout is tied 0; WAIT_HIGH may last indefinitely.

Decomposition:
- Package i2c_pkg: state enum (IDLE, LOW, WAIT_HIGH, HIGH), constant HP_MIN=2, constant SYNC_STAGES=2.
- Sub-module i2c_sync2: 2-flop synchroniser with reset value 1, shared with the SDA input path.

Test Plan:
- Free run: hp=10, scl_in=scl_out, en=1 → period 23 cycles; strob_down then strob_mid_low 5 cycles later; strob_up 13 cycles after strob_down; strob_mid_high 5 cycles after strob_up.
- Stretch: hp=10, slave holds scl_in low 20 cycles after release → stretching high for 23 cycles; strob_up delayed by 20 cycles; HIGH still lasts 10 cycles.
- Stop mid-low: en dropped in LOW with hp=8 → the LOW and HIGH phases complete, then IDLE; scl_out=1 and busy=0 one cycle after HIGH ends.
- Clamp and reprogram: half_period=0 → low phase 2 cycles; half_period written to 6 mid-phase → the current phase is unchanged, the next phase lasts 6 cycles.
- Reset mid-HIGH: rst pulsed with count==3 → the next cycle shows scl_out=1, all strobes 0, busy=0; with en=1 afterwards, LOW restarts cleanly.
- Timeout (with I2C_STRETCH_TIMEOUT_EN): stretch_limit=50, scl_in held low forever → one timeout pulse about 50 cycles into WAIT_HIGH, then IDLE, scl_out=1.
